// File: rtl/axi_light_regfile_if.sv
// if_axi_light: AXI-lite bus bundle shared by masters, interconnect and responders.
//   aw*: write address (awaddr, awprot, awvalid, awready)
//   w* : write data    (wdata, wstrb, wvalid, wready)
//   b* : write resp    (bresp, bvalid, bready)
//   ar*: read address  (araddr, arprot, arvalid, arready)
//   r* : read data     (rdata, rresp, rvalid, rready)
// Address width is `AXI_ADDR_WIDTH (defaults to 32), data is fixed at 32 bits.

`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif

interface if_axi_light;
    logic [`AXI_ADDR_WIDTH-1:0] awaddr;
    logic [2:0]                 awprot;
    logic                       awvalid;
    logic                       awready;

    logic [31:0]                wdata;
    logic [3:0]                 wstrb;
    logic                       wvalid;
    logic                       wready;

    logic [1:0]                 bresp;
    logic                       bvalid;
    logic                       bready;

    logic [`AXI_ADDR_WIDTH-1:0] araddr;
    logic [2:0]                 arprot;
    logic                       arvalid;
    logic                       arready;

    logic [31:0]                rdata;
    logic [1:0]                 rresp;
    logic                       rvalid;
    logic                       rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axi_light_regfile.sv
// axi_light_regfile: AXI-lite responder backed by NUM_REGS 32-bit read/write registers.
//
// Ports:
//   clk        - single clock, rising edge
//   resetn     - synchronous active-low reset
//   s_axi      - AXI-lite slave port (if_axi_light.slave)
//   regs_o     - register contents, reg i at [32*i +: 32]
//   wr_pulse_o - one-cycle pulse per register, high in the cycle after it is written
//
// AW and W are captured in independent one-deep slots; a write commits once both slots are
// full and the B channel can take a new response. Reads complete in a single cycle.
// Addresses outside BASE_ADDR .. BASE_ADDR + 4*NUM_REGS - 1 answer SLVERR.
// The register index is taken from offset bits [9:2], so `AXI_ADDR_WIDTH must be >= 10.

`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif

module axi_light_regfile #(
    parameter logic [`AXI_ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int unsigned                NUM_REGS    = 16,
    parameter logic [31:0]                RESET_VALUE = 32'h0
) (
    input  logic                      clk,
    input  logic                      resetn,
    if_axi_light.slave                s_axi,
    output logic [NUM_REGS*32-1:0]    regs_o,
    output logic [NUM_REGS-1:0]       wr_pulse_o
);

    localparam int unsigned AW      = `AXI_ADDR_WIDTH;
    // One extra bit so a 256-register window still compares correctly with narrow buses.
    localparam logic [AW:0] WinSize = (AW + 1)'(4 * NUM_REGS);

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlverr = 2'b10;

    // Write holding slots
    logic                aw_full_q, aw_full_d;
    logic [AW-1:0]       aw_addr_q, aw_addr_d;
    logic                w_full_q, w_full_d;
    logic [31:0]         w_data_q, w_data_d;
    logic [3:0]          w_strb_q, w_strb_d;

    // Response channels
    logic                bvalid_q, bvalid_d;
    logic [1:0]          bresp_q, bresp_d;
    logic                rvalid_q, rvalid_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [1:0]          rresp_q, rresp_d;

    // Register bank
    logic [31:0]         regs_q [NUM_REGS];
    logic [31:0]         regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;

    logic                aw_hs, w_hs, ar_hs, commit;
    logic [AW-1:0]       aw_off, ar_off;
    logic                aw_hit, ar_hit;
    logic [31:0]         rd_word;

    logic                unused_prot;
    assign unused_prot = ^{s_axi.awprot, s_axi.arprot};

    // Ready signals depend only on internal state and rready.
    assign s_axi.awready = !aw_full_q;
    assign s_axi.wready  = !w_full_q;
    assign s_axi.arready = !rvalid_q || s_axi.rready;

    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = rresp_q;

    assign aw_hs  = s_axi.awvalid && !aw_full_q;
    assign w_hs   = s_axi.wvalid && !w_full_q;
    assign ar_hs  = s_axi.arvalid && (!rvalid_q || s_axi.rready);
    // A commit may reuse the B slot on the same edge its previous beat is accepted.
    assign commit = aw_full_q && w_full_q && (!bvalid_q || s_axi.bready);

    // Offsets wrap modulo 2^AW, so addresses below BASE_ADDR land far outside the window.
    assign aw_off = aw_addr_q - BASE_ADDR;
    assign ar_off = s_axi.araddr - BASE_ADDR;
    assign aw_hit = ({1'b0, aw_off} < WinSize);
    assign ar_hit = ({1'b0, ar_off} < WinSize);

    // AW / W slots. A slot cannot fill and drain on the same edge: while full its ready is low.
    always_comb begin
        aw_full_d = aw_full_q;
        aw_addr_d = aw_addr_q;
        w_full_d  = w_full_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;

        if (commit) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
        end else begin
            if (aw_hs) begin
                aw_full_d = 1'b1;
                aw_addr_d = s_axi.awaddr;
            end
            if (w_hs) begin
                w_full_d = 1'b1;
                w_data_d = s_axi.wdata;
                w_strb_d = s_axi.wstrb;
            end
        end
    end

    // Register bank update and write pulses.
    always_comb begin
        regs_d     = regs_q;
        wr_pulse_d = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (commit && aw_hit && (aw_off[9:2] == 8'(i))) begin
                wr_pulse_d[i] = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    if (w_strb_q[k]) begin
                        regs_d[i][8*k +: 8] = w_data_q[8*k +: 8];
                    end
                end
            end
        end
    end

    // B channel
    always_comb begin
        bvalid_d = bvalid_q;
        bresp_d  = bresp_q;
        if (commit) begin
            bvalid_d = 1'b1;
            bresp_d  = aw_hit ? RespOkay : RespSlverr;
        end else if (s_axi.bready) begin
            bvalid_d = 1'b0;
        end
    end

    // Read mux sees the bank as it stands before this edge, so a same-edge write is not visible.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (ar_off[9:2] == 8'(i)) begin
                rd_word = regs_q[i];
            end
        end
    end

    // R channel
    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = ar_hit ? rd_word : 32'h0;
            rresp_d  = ar_hit ? RespOkay : RespSlverr;
        end else if (s_axi.rready) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            aw_full_q  <= 1'b0;
            aw_addr_q  <= '0;
            w_full_q   <= 1'b0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RespOkay;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RespOkay;
            wr_pulse_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= RESET_VALUE;
            end
        end else begin
            aw_full_q  <= aw_full_d;
            aw_addr_q  <= aw_addr_d;
            w_full_q   <= w_full_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            wr_pulse_q <= wr_pulse_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    always_comb begin
        regs_o = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_o[32*i +: 32] = regs_q[i];
        end
    end

    assign wr_pulse_o = wr_pulse_q;

endmodule
